// File: rtl/fact_pkg.sv
// Shared widths, FSM state encoding and factor bounds for the factor search block.
package fact_pkg;
  localparam int W_PROD_DEF = 10;
  localparam int W_FAC_DEF  = 5;
  localparam int FAC_MIN    = 2;
  localparam int FAC_MAX    = 31;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DIV,
    S_CHECK,
    S_DONE
  } state_e;
endpackage

// File: rtl/fact_div.sv
// Sequential restoring divider: one quotient bit per i_step, MSB first.
// The quotient bits replace the dividend bits in r_q as the dividend shifts out.
module fact_div #(
  parameter int W_PROD = 10,
  parameter int W_FAC  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [W_PROD-1:0] i_dividend,
  input  logic [W_FAC-1:0]  i_divisor,
  output logic [W_PROD-1:0] o_quot,
  output logic [W_FAC:0]    o_rem
);
  logic [W_PROD-1:0] r_q;
  logic [W_FAC:0]    r_r;
  logic [W_FAC-1:0]  r_div;
  logic [W_FAC:0]    w_trial;
  logic [W_FAC:0]    w_diff;
  logic              w_ge;

  // The remainder is always below the divisor, so its low W_FAC bits plus the next dividend bit fit.
  assign w_trial = {r_r[W_FAC-1:0], r_q[W_PROD-1]};
  assign w_ge    = w_trial >= {1'b0, r_div};
  assign w_diff  = w_trial - {1'b0, r_div};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      r_r   <= '0;
      r_div <= '0;
    end else if (i_load) begin
      r_q   <= i_dividend;
      r_r   <= '0;
      r_div <= i_divisor;
    end else if (i_step) begin
      r_q <= {r_q[W_PROD-2:0], w_ge};
      r_r <= w_ge ? w_diff : w_trial;
    end
  end

  assign o_quot = r_q;
  assign o_rem  = r_r;
endmodule

// File: rtl/fact_search.sv
// Finds the smallest divisor d in 2..31 of a target whose cofactor is also in 2..31,
// trying one candidate per LOAD/DIV/CHECK round (12 cycles at default widths).
module fact_search
  import fact_pkg::*;
#(
  parameter int W_PROD = W_PROD_DEF,
  parameter int W_FAC  = W_FAC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [W_PROD-1:0] i_a,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_found,
  output logic [W_FAC-1:0]  o_f1,
  output logic [W_FAC-1:0]  o_f2
);
  localparam int CW = $clog2(W_PROD);
  localparam logic [W_PROD-1:0] QMIN = W_PROD'(FAC_MIN);
  localparam logic [W_PROD-1:0] QMAX = W_PROD'(FAC_MAX);
  localparam logic [W_FAC-1:0]  DMIN = W_FAC'(FAC_MIN);
  localparam logic [W_FAC-1:0]  DMAX = W_FAC'(FAC_MAX);

  state_e            r_state, w_next;
  logic [W_PROD-1:0] r_a;
  logic [W_FAC-1:0]  r_d;
  logic [CW-1:0]     r_cnt;
  logic              r_found;
  logic [W_FAC-1:0]  r_f1, r_f2;
  logic              w_load, w_step, w_hit, w_stop;
  logic [W_PROD-1:0] w_quot;
  logic [W_FAC:0]    w_rem;

  fact_div #(.W_PROD(W_PROD), .W_FAC(W_FAC)) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_step     (w_step),
    .i_dividend (r_a),
    .i_divisor  (r_d),
    .o_quot     (w_quot),
    .o_rem      (w_rem)
  );

  assign w_hit  = (w_rem == '0) && (w_quot >= QMIN) && (w_quot <= QMAX);
  // Once q < d every larger divisor would pair with an already-rejected smaller one.
  assign w_stop = (w_quot < W_PROD'(r_d)) || (r_d == DMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_LOAD;
      S_LOAD: begin
        w_load = 1'b1;
        w_next = S_DIV;
      end
      S_DIV: begin
        w_step = 1'b1;
        if (r_cnt == CW'(W_PROD-1)) w_next = S_CHECK;
      end
      S_CHECK: w_next = (w_hit || w_stop) ? S_DONE : S_LOAD;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_found <= 1'b0;
      r_f1    <= '0;
      r_f2    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_a     <= i_a;
          r_d     <= DMIN;
          r_found <= 1'b0;
          r_f1    <= '0;
          r_f2    <= '0;
        end
        S_LOAD: r_cnt <= '0;
        S_DIV:  r_cnt <= r_cnt + 1'b1;
        S_CHECK: begin
          if (w_hit) begin
            r_found <= 1'b1;
            r_f1    <= r_d;
            r_f2    <= w_quot[W_FAC-1:0];
          end else if (!w_stop) begin
            r_d <= r_d + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy  = (r_state != S_IDLE);
  assign o_done  = (r_state == S_DONE);
  assign o_found = r_found;
  assign o_f1    = r_f1;
  assign o_f2    = r_f2;
endmodule

// File: doc/fact_search.md
FACT_SEARCH -- requirements
Module: fact_search

Interface
REQ-001 Parameter W_PROD, default 10, product (target) width.
REQ-002 Parameter W_FAC, default 5, factor width; W_PROD SHALL equal 2*W_FAC.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request a search; sampled only in IDLE.
REQ-006 a  input  W_PROD  target product; captured on the accepted start.
REQ-007 busy  output  1  high from the cycle after start acceptance until DONE exits.
REQ-008 done  output  1  one-cycle pulse marking result valid.
REQ-009 found  output  1  a nontrivial factor pair exists.
REQ-010 f1  output  W_FAC  smaller factor; valid when found.
REQ-011 f2  output  W_FAC  larger factor; valid when found.

Function
REQ-012 Goal: return the smallest d in 2..31 with a mod d == 0 and 2 <= a/d <= 31; f1=d, f2=a/d.
- Since d is the smallest such divisor, f1 <= f2 always holds.
REQ-013 States: IDLE, LOAD, DIV, CHECK, DONE.
REQ-014 IDLE with start=1: capture a, set d=2, go to LOAD.
- found, f1 and f2 clear at start acceptance.
REQ-015 LOAD, 1 cycle: initialise divider with dividend a and divisor d.
REQ-016 DIV, exactly W_PROD cycles: restoring division, one quotient bit per cycle, MSB first.
- Remainder register width is W_FAC+1.
REQ-017 CHECK, 1 cycle, with quotient q and remainder r:
- r==0 and 2<=q<=31: set found=1, f1=d, f2=q[4:0]; go to DONE.
- else if q<d or d==31: go to DONE with found=0.
- else: d=d+1; go to LOAD.
REQ-018 Each candidate costs 12 cycles.
- done SHALL assert 12*N+1 cycles after the start-sampling edge, where N is the number of candidates examined.
REQ-019 DONE, 1 cycle: done=1, then return to IDLE.
REQ-020 found, f1 and f2 SHALL hold their values until the next accepted start.
REQ-021 start while busy SHALL be ignored; a is not re-sampled.
REQ-022 start asserted in the DONE cycle SHALL be ignored; the request is accepted only in IDLE.
REQ-023 a<4, a=0 and a=1 SHALL terminate after one candidate with found=0.
- Cause: q<2 at d=2.
REQ-024 Counter d SHALL never wrap; the maximum is 31.

Reset
REQ-025 rst_n low, at any time including mid-search, SHALL force IDLE asynchronously.
- Outputs busy=0, done=0, found=0, f1=0, f2=0.
- Internal d, quotient and remainder cleared.
REQ-026 The first start is accepted on the first rising edge with rst_n high.

Structure
REQ-027 Shared package fact_pkg SHALL hold W_PROD/W_FAC defaults, the state enum and constants FAC_MIN=2 and FAC_MAX=31.
REQ-028 Divider SHALL be a sub-module fact_div with load, step, quotient and remainder ports.
- fact_div is a sequential restoring divider, W_PROD by W_FAC, controlled by the fact_search FSM.
REQ-029 Total RTL target: 150-300 lines.

Verification
REQ-030 a=6, start pulse -> done 13 cycles after start; found=1, f1=2, f2=3.
REQ-031 a=961 -> found=1, f1=31, f2=31.
- Timing: done at cycle 361 (30 candidates).
REQ-032 a=124 -> found=1, f1=4, f2=31.
- d=2 is rejected because q=62>31.
REQ-033 a=1021 (prime) and a=1023 (no pair <=31) -> found=0, done at cycle 361.
- a=7 -> found=0, done at cycle 25 (early stop when q<d).
REQ-034 start=1 with a=15 while busy on a=6 -> result 2,3 only; done pulses once.
- rst_n low mid-search -> all outputs 0 immediately.
- A new start after reset returns the correct result.
